cdb_arbiter: RTL and testbench

- Transmitting end of the common data bus (CDB).
- Collects completed results (tag, value) from the functional units (ALU, load, store, branch, ...), buffers them per unit, and broadcasts one result per cycle to every reservation station and the register map.
- Arbitration between units is round-robin.
- Output is registered, so all consumers see a stable cdb_t for a full cycle.

---
 rtl/cpu_types.sv | 32 +++
 rtl/cdb_result_fifo.sv | 81 ++++++++
 rtl/cdb_arbiter.sv | 113 +++++++++++
 tb/tb_cdb_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types.sv
// Shared CPU types: reservation-station tags, the CDB bundle and
// the CDB source index used by the result-bus arbiter.
package cpu_types;

    localparam int RS_TAG_W = 5;

    typedef logic [RS_TAG_W-1:0] RS_tag_type;

    // Tag 0 never names a reservation station, so it marks "no result".
    localparam RS_tag_type INVALID = '0;

    typedef struct packed {
        RS_tag_type  tag;
        logic [31:0] data;
    } cdb_t;

    localparam cdb_t CDB_IDLE = '{tag: INVALID, data: 32'h0};

    localparam int NUM_CDB_SRC = 4;
    localparam int CDB_SRC_W   = (NUM_CDB_SRC > 1) ? $clog2(NUM_CDB_SRC) : 1;

    typedef logic [CDB_SRC_W-1:0] cdb_src_idx_t;

    // Successor of a source index with wrap-around over n sources.
    function automatic cdb_src_idx_t next_src(input cdb_src_idx_t i,
                                              input int n);
        if (int'(i) == n - 1)
            return '0;
        return i + 1'b1;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-unit result buffer feeding the CDB arbiter: a small FIFO of
// (tag, data) pairs with occupancy count and synchronous squash.
module cdb_result_fifo
    import cpu_types::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        push,
    input  RS_tag_type  tag_in,
    input  logic [31:0] data_in,
    input  logic        pop,
    output RS_tag_type  head_tag,
    output logic [31:0] head_data,
    output logic        empty,
    output logic        full
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    RS_tag_type  tag_mem  [BUF_DEPTH];
    logic [31:0] data_mem [BUF_DEPTH];

    logic do_push;
    logic do_pop;

    // Power-of-two depth wraps naturally; a single entry stays at 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (BUF_DEPTH == 1)
            return '0;
        return p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(BUF_DEPTH));

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_tag  = tag_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Pointer and occupancy bookkeeping; squash empties the buffer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are meaningless while empty.
    always_ff @(posedge CLK) begin
        if (do_push && !flush) begin
            tag_mem[wr_ptr]  <= tag_in;
            data_mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit side: buffers unit results, round-robin grants one per
// cycle into a registered broadcast. CDB_PERF_EN adds stall_cycles.
module cdb_arbiter
    import cpu_types::*;
#(
    parameter int NUM_FU    = NUM_CDB_SRC,
    parameter int BUF_DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic [NUM_FU-1:0]      fu_valid,
    input  RS_tag_type [NUM_FU-1:0] fu_tag,
    input  logic [NUM_FU-1:0][31:0] fu_data,
    output logic [NUM_FU-1:0]      fu_ready,
    output cdb_t                   cdb_out,
`ifdef CDB_PERF_EN
    output logic                   cdb_valid,
    output logic [31:0]            stall_cycles
`else
    output logic                   cdb_valid
`endif
);

    logic [NUM_FU-1:0] empty;
    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] grant;

    RS_tag_type [NUM_FU-1:0]  head_tag;
    logic [NUM_FU-1:0][31:0] head_data;

    cdb_src_idx_t rr_ptr;
    cdb_src_idx_t winner;
    cdb_src_idx_t idx;
    logic         found;

    // Readiness comes from buffer state alone, never from fu_valid.
    assign fu_ready = ~full;

    // An INVALID tag completes the handshake but is not stored.
    always_comb begin
        push = '0;
        for (int i = 0; i < NUM_FU; i++)
            push[i] = fu_valid[i] && fu_ready[i] &&
                      (fu_tag[i] != INVALID) && !flush;
    end

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
        cdb_result_fifo #(
            .BUF_DEPTH (BUF_DEPTH)
        ) u_fifo (
            .CLK       (CLK),
            .RST       (RST),
            .flush     (flush),
            .push      (push[g]),
            .tag_in    (fu_tag[g]),
            .data_in   (fu_data[g]),
            .pop       (grant[g]),
            .head_tag  (head_tag[g]),
            .head_data (head_data[g]),
            .empty     (empty[g]),
            .full      (full[g])
        );
    end

    // Round-robin search from rr_ptr upward for the first non-empty buffer.
    always_comb begin
        grant  = '0;
        winner = rr_ptr;
        idx    = rr_ptr;
        found  = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = cdb_src_idx_t'((int'(rr_ptr) + k) % NUM_FU);
            if (!found && !empty[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        if (found && !flush)
            grant[winner] = 1'b1;
    end

    // Broadcast register and round-robin pointer; squash keeps rr_ptr.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cdb_out   <= CDB_IDLE;
            cdb_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_out   <= CDB_IDLE;
            cdb_valid <= 1'b0;
        end else if (found) begin
            cdb_out   <= '{tag: head_tag[winner], data: head_data[winner]};
            cdb_valid <= 1'b1;
            rr_ptr    <= next_src(winner, NUM_FU);
        end else begin
            cdb_out   <= CDB_IDLE;
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_PERF_EN
    // Counts edges where some unit is blocked by a full buffer; saturates.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_cycles <= '0;
        else if (|(fu_valid & ~fu_ready) && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table for single-cycle
// behaviour plus scripted fairness, backpressure and flush sequences.
module tb_cdb_arbiter;
    import cpu_types::*;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  flush;
    logic [3:0]            fu_valid;
    RS_tag_type [3:0]      fu_tag;
    logic [3:0][31:0]      fu_data;
    logic [3:0]            fu_ready;
    cdb_t                  cdb_out;
    logic                  cdb_valid;
`ifdef CDB_PERF_EN
    logic [31:0]           stall_cycles;
`endif

    cdb_arbiter #(
        .NUM_FU    (4),
        .BUF_DEPTH (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_data   (fu_data),
        .fu_ready  (fu_ready),
        .cdb_out   (cdb_out),
`ifdef CDB_PERF_EN
        .cdb_valid (cdb_valid),
        .stall_cycles (stall_cycles)
`else
        .cdb_valid (cdb_valid)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]       valid;
        RS_tag_type [3:0] tag;
        logic [3:0][31:0] data;
        logic             exp_v;
        RS_tag_type       exp_tag;
        logic [31:0]      exp_data;
        logic [3:0]       exp_rdy;
    } vec_t;

    vec_t tbl [9];

    logic [36:0] sbq [4][$];
    int          nsend [4];
    int          bcasts;
    bit          saw_stall0;

    function automatic RS_tag_type mk_tag(input int i, input int s);
        return RS_tag_type'(1 + i * 7 + s);
    endfunction

    function automatic logic [31:0] mk_data(input int i, input int s);
        return 32'hA000_0000 | 32'(i * 256 + s);
    endfunction

    task automatic do_reset();
        RST      = 1'b1;
        flush    = 1'b0;
        fu_valid = '0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Each unit sends nsend[i] results; every broadcast is checked against
    // the per-unit acceptance queue, and optionally against strict rotation.
    task automatic run_traffic(input int ncycles, input bit check_order);
        int          sent [4];
        logic [3:0]  xfer;
        int          exp_unit;
        int          u;
        logic [36:0] front;
        for (int i = 0; i < 4; i++) begin
            sent[i] = 0;
            sbq[i].delete();
        end
        xfer       = '0;
        exp_unit   = 0;
        bcasts     = 0;
        saw_stall0 = 1'b0;
        for (int c = 0; c < ncycles; c++) begin
            @(negedge CLK);
            if (cdb_valid) begin
                u = (int'(cdb_out.tag) - 1) / 7;
                bcasts++;
                if (check_order) begin
                    chk("rr_order", 64'(u), 64'(exp_unit));
                    exp_unit = (exp_unit + 1) % 4;
                end
                if (cdb_out.tag == INVALID || u > 3 || sbq[u].size() == 0) begin
                    chk("unexpected_bcast", {63'b0, cdb_valid}, 64'd0);
                end else begin
                    front = sbq[u].pop_front();
                    chk("bcast_tag", 64'(cdb_out.tag), 64'(front[36:32]));
                    chk("bcast_data", 64'(cdb_out.data), 64'(front[31:0]));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (xfer[i]) begin
                    sbq[i].push_back({fu_tag[i], fu_data[i]});
                    sent[i]++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                fu_valid[i] = (sent[i] < nsend[i]);
                fu_tag[i]   = mk_tag(i, sent[i]);
                fu_data[i]  = mk_data(i, sent[i]);
            end
            if (fu_valid[0] && !fu_ready[0])
                saw_stall0 = 1'b1;
            xfer = fu_valid & fu_ready;
        end
        fu_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 9; r++) begin
            tbl[r].valid    = '0;
            tbl[r].tag      = '0;
            tbl[r].data     = '0;
            tbl[r].exp_v    = 1'b0;
            tbl[r].exp_tag  = INVALID;
            tbl[r].exp_data = '0;
            tbl[r].exp_rdy  = 4'hF;
        end
        tbl[0].valid    = 4'b0010;
        tbl[0].tag[1]   = 5'd3;
        tbl[0].data[1]  = 32'hDEAD_BEEF;
        tbl[1].exp_v    = 1'b1;
        tbl[1].exp_tag  = 5'd3;
        tbl[1].exp_data = 32'hDEAD_BEEF;
        tbl[3].valid    = 4'b1001;
        tbl[3].tag[0]   = 5'd5;
        tbl[3].data[0]  = 32'h50;
        tbl[3].tag[3]   = 5'd6;
        tbl[3].data[3]  = 32'h60;
        tbl[4].exp_v    = 1'b1;
        tbl[4].exp_tag  = 5'd6;
        tbl[4].exp_data = 32'h60;
        tbl[5].exp_v    = 1'b1;
        tbl[5].exp_tag  = 5'd5;
        tbl[5].exp_data = 32'h50;
        tbl[7].valid    = 4'b0100;
        tbl[7].tag[2]   = INVALID;
        tbl[7].data[2]  = 32'h77;

        // Reset with all units requesting: nothing may be captured.
        RST      = 1'b1;
        flush    = 1'b0;
        fu_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            fu_tag[i]  = mk_tag(i, 0);
            fu_data[i] = mk_data(i, 0);
        end
        repeat (3) @(negedge CLK);
        RST      = 1'b0;
        fu_valid = '0;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag", 64'(cdb_out.tag), 64'(INVALID));
        chk("rst_data", 64'(cdb_out.data), 64'd0);
        chk("rst_ready", 64'(fu_ready), 64'hF);
        @(negedge CLK);
        chk("rst_empty", 64'(cdb_valid), 64'd0);
`ifdef CDB_PERF_EN
        chk("rst_stall", 64'(stall_cycles), 64'd0);
`endif

        for (int r = 0; r < 9; r++) begin
            fu_valid = tbl[r].valid;
            fu_tag   = tbl[r].tag;
            fu_data  = tbl[r].data;
            @(negedge CLK);
            chk($sformatf("vec%0d_valid", r), 64'(cdb_valid), 64'(tbl[r].exp_v));
            chk($sformatf("vec%0d_tag", r), 64'(cdb_out.tag), 64'(tbl[r].exp_tag));
            chk($sformatf("vec%0d_data", r), 64'(cdb_out.data), 64'(tbl[r].exp_data));
            chk($sformatf("vec%0d_ready", r), 64'(fu_ready), 64'(tbl[r].exp_rdy));
        end
        fu_valid = '0;

        // Fairness: all buffers kept busy, strict 0,1,2,3 rotation.
        do_reset();
        for (int i = 0; i < 4; i++)
            nsend[i] = 7;
        run_traffic(36, 1'b1);
        chk("fair_count", 64'(bcasts), 64'd28);
        for (int i = 0; i < 4; i++)
            chk($sformatf("fair_left%0d", i), 64'(sbq[i].size()), 64'd0);

        // Backpressure: rr_ptr moved to 1 first, then FU0 sends three.
        do_reset();
        nsend = '{1, 0, 0, 0};
        run_traffic(4, 1'b0);
        chk("pre_count", 64'(bcasts), 64'd1);
        nsend = '{3, 1, 1, 1};
        run_traffic(12, 1'b0);
        chk("bp_count", 64'(bcasts), 64'd6);
        chk("bp_stall_seen", 64'(saw_stall0), 64'd1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp_left%0d", i), 64'(sbq[i].size()), 64'd0);
`ifdef CDB_PERF_EN
        chk("bp_stall_cycles", 64'(stall_cycles), 64'd3);
`endif

        // Flush: rr_ptr set to 1, buffers filled, squash, then reuse.
        do_reset();
        fu_valid   = 4'b0001;
        fu_tag[0]  = 5'd9;
        fu_data[0] = 32'h9;
        @(negedge CLK);
        fu_valid = '0;
        @(negedge CLK);
        chk("pre_flush_valid", 64'(cdb_valid), 64'd1);
        chk("pre_flush_tag", 64'(cdb_out.tag), 64'd9);
        fu_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            fu_tag[i]  = RS_tag_type'(10 + i);
            fu_data[i] = 32'(100 + i);
        end
        @(negedge CLK);
        chk("fill_valid", 64'(cdb_valid), 64'd0);
        flush      = 1'b1;
        fu_valid   = 4'b0001;
        fu_tag[0]  = 5'd14;
        fu_data[0] = 32'd104;
        @(negedge CLK);
        flush    = 1'b0;
        fu_valid = '0;
        chk("flush_valid", 64'(cdb_valid), 64'd0);
        chk("flush_tag", 64'(cdb_out.tag), 64'(INVALID));
        chk("flush_data", 64'(cdb_out.data), 64'd0);
        chk("flush_ready", 64'(fu_ready), 64'hF);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("flush_quiet", 64'(cdb_valid), 64'd0);
        end
        fu_valid   = 4'b0011;
        fu_tag[0]  = 5'd21;
        fu_data[0] = 32'd21;
        fu_tag[1]  = 5'd22;
        fu_data[1] = 32'd22;
        @(negedge CLK);
        fu_valid = '0;
        @(negedge CLK);
        chk("post_flush_first", 64'(cdb_out.tag), 64'd22);
        chk("post_flush_first_v", 64'(cdb_valid), 64'd1);
        @(negedge CLK);
        chk("post_flush_second", 64'(cdb_out.tag), 64'd21);
        chk("post_flush_second_d", 64'(cdb_out.data), 64'd21);
        @(negedge CLK);
        chk("post_flush_idle", 64'(cdb_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
